// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch unit and its bimodal predictor.
//   OP_BRANCH / OP_JAL / OP_JALR : RV32 opcodes resolved by the branch unit
//   br_type_e                    : funct3 encodings of conditional branches
//   bht_state_e                  : 2-bit saturating counter states
//   bht_next()                   : counter training step
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET_STATE = BHT_WNT;

    // Saturating increment on taken, saturating decrement on not-taken.
    function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
        bht_state_e n;
        case (s)
            BHT_SNT: n = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: n = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  n = taken ? BHT_ST  : BHT_WNT;
            default: n = taken ? BHT_ST  : BHT_WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator, purely combinational.
//   rs1, rs2 : XLEN-bit operands
//   br_type  : funct3 of the conditional branch
//   cond     : 1 when the branch condition holds (010/011 never hold)
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      br_type,
    output logic            cond
);

    always_comb begin
        cond = 1'b0;
        case (br_type)
            BR_EQ:   cond = (rs1 == rs2);
            BR_NE:   cond = (rs1 != rs2);
            BR_LT:   cond = ($signed(rs1) <  $signed(rs2));
            BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  cond = (rs1 <  rs2);
            BR_GEU:  cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolution plus bimodal branch history table (BHT).
//   clk, rst            : clock, asynchronous active-high reset
//   if_pc               : fetch PC, if_pred_taken is the BHT prediction for it
//   ex_valid, ex_pc     : EX instruction valid flag and PC
//   ex_opcode, ex_br_type, ex_rs1, ex_rs2 : EX decode fields and operands
//   ex_pred_taken       : prediction made in IF for the EX instruction
//   br_taken            : redirect required (taken branch or any jump)
//   mispredict          : conditional-branch outcome differs from prediction
//   stat_branches, stat_mispredicts : event counters
// Optional feature macro: BRANCH_PREDICT_STATS_EN builds the stat counters;
// without it both stat ports are tied to zero.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_br_type,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_pred_taken,
    output logic            br_taken,
    output logic            mispredict,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_is_branch;
    logic             w_is_jump;
    logic             w_cond;
    bht_state_e       w_if_state;
    logic             w_unused;

    bht_state_e r_bht [BHT_ENTRIES];

    // Word-aligned PCs: drop the two byte-offset bits.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];

    assign w_is_branch = ex_valid & (ex_opcode == OP_BRANCH);
    assign w_is_jump   = ex_valid & ((ex_opcode == OP_JAL) | (ex_opcode == OP_JALR));

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .br_type (ex_br_type),
        .cond    (w_cond)
    );

    assign br_taken   = w_is_jump | (w_is_branch & w_cond);
    assign mispredict = w_is_branch & (w_cond != ex_pred_taken);

    // No write-to-read bypass: a same-index read sees the pre-update counter.
    assign w_if_state    = r_bht[w_if_idx];
    assign if_pred_taken = w_if_state[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bht <= '{default: BHT_RESET_STATE};
        end else if (w_is_branch) begin
            r_bht[w_ex_idx] <= bht_next(r_bht[w_ex_idx], w_cond);
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_is_branch) r_stat_branches    <= r_stat_branches + 32'd1;
            if (mispredict)  r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    // PC bits outside the index field carry no predictor information.
    assign w_unused = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                        ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

endmodule
